// File: rtl/operand_fetch_if.sv
// Operand fetch stage bus: decoded-instruction input, operand bundle toward the
// ALU, and the ALU writeback port.
interface operand_fetch_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic              inValid;
  logic              inReady;
  logic [2:0]        rs;
  logic [2:0]        rt;
  logic [2:0]        rd;
  logic [DATA_W-1:0] imm;
  logic              useImm;
  logic [2:0]        aluOpIn;
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [2:0]        aluOperation;
  logic [2:0]        dstReg;
  logic              wbEn;
  logic [2:0]        wbAddr;
  logic [DATA_W-1:0] wbData;

  modport master (
    output inValid, rs, rt, rd, imm, useImm, aluOpIn, outReady, wbEn, wbAddr, wbData,
    input  inReady, outValid, a, b, aluOperation, dstReg
  );

  modport slave (
    input  inValid, rs, rt, rd, imm, useImm, aluOpIn, outReady, wbEn, wbAddr, wbData,
    output inReady, outValid, a, b, aluOperation, dstReg
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file with writeback bypass, per-register pending
// scoreboard, and a one-deep registered operand bundle toward the ALU.
module operand_fetch #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_N  = 8
) (
  input logic            clk,
  input logic            rst,
  operand_fetch_if.slave bus
);
  localparam int unsigned AddrW = 3;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] regs_q [REG_N];
  logic [REG_N-1:0]  pending_q, pending_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0]        op_q;
  logic [AddrW-1:0]  dst_q;

  logic [DATA_W-1:0] rd_a, rd_b;
  logic              wb_hit_rs, wb_hit_rt;
  logic              haz_rs, haz_rt, hazard;
  logic              accept, consume;

  assign wb_hit_rs = bus.wbEn && (bus.wbAddr == bus.rs);
  assign wb_hit_rt = bus.wbEn && (bus.wbAddr == bus.rt);

  // Register 0 reads as zero and is never bypassed.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (bus.rs != '0) rd_a = wb_hit_rs ? bus.wbData : regs_q[bus.rs];
    if (bus.rt != '0) rd_b = wb_hit_rt ? bus.wbData : regs_q[bus.rt];
  end

  // A same-cycle writeback to a pending source resolves the hazard via bypass.
  assign haz_rs = (bus.rs != '0) && pending_q[bus.rs] && !wb_hit_rs;
  assign haz_rt = !bus.useImm && (bus.rt != '0) && pending_q[bus.rt] && !wb_hit_rt;
  assign hazard = haz_rs || haz_rt;

  assign bus.outValid     = (state_q == StFull);
  assign bus.inReady      = (!bus.outValid || bus.outReady) && !hazard;
  assign accept           = bus.inValid && bus.inReady;
  assign consume          = bus.outValid && bus.outReady;
  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.aluOperation = op_q;
  assign bus.dstReg       = dst_q;

  // Set is applied after clear so a simultaneous set wins.
  always_comb begin
    pending_d = pending_q;
    if (bus.wbEn) pending_d[bus.wbAddr] = 1'b0;
    if (accept && (bus.rd != '0)) pending_d[bus.rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      pending_q <= '0;
      regs_q    <= '{default: '0};
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      dst_q     <= '0;
    end else begin
      pending_q <= pending_d;
      if (bus.wbEn && (bus.wbAddr != '0)) regs_q[bus.wbAddr] <= bus.wbData;

      case (state_q)
        StEmpty: if (accept) state_q <= StFull;
        StFull:  if (consume && !accept) state_q <= StEmpty;
        default: state_q <= StEmpty;
      endcase

      if (accept) begin
        a_q   <= rd_a;
        b_q   <= bus.useImm ? bus.imm : rd_b;
        op_q  <= bus.aluOpIn;
        dst_q <= bus.rd;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios with literal expectations plus a
// cycle-by-cycle comparison against an array/scoreboard model of the stage.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_fetch_if #(.DATA_W(16)) bus ();
  operand_fetch #(.DATA_W(16), .REG_N(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: architectural registers, pending flags, and the held bundle.
  logic [15:0] m_reg [8];
  bit          m_pend [8];
  bit          m_valid;
  logic [15:0] m_a, m_b;
  logic [2:0]  m_op, m_dst;
  bit          live = 1'b0;
  bit          m_acc;

  function automatic logic [15:0] m_read(input logic [2:0] r);
    if (r == 3'd0) return 16'h0000;
    if (bus.wbEn && bus.wbAddr == r) return bus.wbData;
    return m_reg[r];
  endfunction

  function automatic bit m_blocked(input logic [2:0] r);
    return (r != 3'd0) && m_pend[r] && !(bus.wbEn && bus.wbAddr == r);
  endfunction

  function automatic bit m_ready();
    return (!m_valid || bus.outReady) && !m_blocked(bus.rs)
           && !(!bus.useImm && m_blocked(bus.rt));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i]  = 16'h0000;
        m_pend[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_a = 16'h0; m_b = 16'h0; m_op = 3'd0; m_dst = 3'd0;
      live = 1'b1;
    end else if (live) begin
      m_acc = bus.inValid && m_ready();
      if (m_acc) begin
        m_a     = m_read(bus.rs);
        m_b     = bus.useImm ? bus.imm : m_read(bus.rt);
        m_op    = bus.aluOpIn;
        m_dst   = bus.rd;
        m_valid = 1'b1;
      end else if (m_valid && bus.outReady) begin
        m_valid = 1'b0;
      end
      if (bus.wbEn && bus.wbAddr != 3'd0) m_reg[bus.wbAddr] = bus.wbData;
      if (bus.wbEn) m_pend[bus.wbAddr] = 1'b0;
      if (m_acc && bus.rd != 3'd0) m_pend[bus.rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("inReady", bus.inReady, m_ready());
      check("outValid", bus.outValid, m_valid);
      if (m_valid) begin
        check("a", bus.a, m_a);
        check("b", bus.b, m_b);
        check("aluOperation", bus.aluOperation, m_op);
        check("dstReg", bus.dstReg, m_dst);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.inValid = 1'b0; bus.rs = 3'd0; bus.rt = 3'd0; bus.rd = 3'd0;
    bus.imm = 16'h0; bus.useImm = 1'b0; bus.aluOpIn = 3'd0;
    bus.wbEn = 1'b0; bus.wbAddr = 3'd0; bus.wbData = 16'h0;
  endtask

  task automatic issue(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic use_imm, input logic [15:0] imm, input logic [2:0] op);
    bus.inValid = 1'b1; bus.rs = rs; bus.rt = rt; bus.rd = rd;
    bus.useImm = use_imm; bus.imm = imm; bus.aluOpIn = op;
  endtask

  initial begin
    idle();
    bus.outReady = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_inReady", bus.inReady, 1);
    check("rst_outValid", bus.outValid, 0);
    check("rst_a", bus.a, 16'h0);

    // Basic register read path.
    step(); bus.wbEn = 1'b1; bus.wbAddr = 3'd3; bus.wbData = 16'h1234;
    step(); bus.wbAddr = 3'd4; bus.wbData = 16'h0F0F;
    step(); bus.wbEn = 1'b0; issue(3'd3, 3'd4, 3'd0, 1'b0, 16'h0, 3'b001);
    step(); idle();
    @(negedge clk);
    check("basic_a", bus.a, 16'h1234);
    check("basic_b", bus.b, 16'h0F0F);
    check("basic_op", bus.aluOperation, 3'b001);
    check("basic_valid", bus.outValid, 1);
    step();
    @(negedge clk);
    check("drain_valid", bus.outValid, 0);

    // Pending hazard on r5, released by a same-cycle writeback.
    step(); issue(3'd1, 3'd2, 3'd5, 1'b0, 16'h0, 3'b010);
    step(); issue(3'd5, 3'd0, 3'd0, 1'b1, 16'h0007, 3'b011);
    @(negedge clk);
    check("hazard_ready", bus.inReady, 0);
    step();
    @(negedge clk);
    check("hazard_ready2", bus.inReady, 0);
    step(); bus.wbEn = 1'b1; bus.wbAddr = 3'd5; bus.wbData = 16'hBEEF;
    @(negedge clk);
    check("bypass_ready", bus.inReady, 1);
    step(); idle();
    @(negedge clk);
    check("bypass_a", bus.a, 16'hBEEF);
    check("bypass_b", bus.b, 16'h0007);

    // Stall holds the bundle despite writes to its source; then back-to-back.
    step(); issue(3'd3, 3'd4, 3'd0, 1'b0, 16'h0, 3'b100); bus.outReady = 1'b0;
    step(); issue(3'd3, 3'd4, 3'd0, 1'b0, 16'h0, 3'b101);
    bus.wbEn = 1'b1; bus.wbAddr = 3'd3; bus.wbData = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_a", bus.a, 16'h1234);
      check("stall_op", bus.aluOperation, 3'b100);
      check("stall_ready", bus.inReady, 0);
      step();
    end
    bus.wbEn = 1'b0; bus.outReady = 1'b1;
    @(negedge clk);
    check("unstall_ready", bus.inReady, 1);
    step(); issue(3'd4, 3'd3, 3'd0, 1'b0, 16'h0, 3'b110);
    @(negedge clk);
    check("b2b1_valid", bus.outValid, 1);
    check("b2b1_a", bus.a, 16'h5555);
    check("b2b1_op", bus.aluOperation, 3'b101);
    step(); idle();
    @(negedge clk);
    check("b2b2_valid", bus.outValid, 1);
    check("b2b2_a", bus.a, 16'h0F0F);
    check("b2b2_b", bus.b, 16'h5555);
    check("b2b2_op", bus.aluOperation, 3'b110);

    // Register 0 ignores writes and is not bypassed.
    step(); bus.wbEn = 1'b1; bus.wbAddr = 3'd0; bus.wbData = 16'hFFFF;
    step(); issue(3'd0, 3'd0, 3'd0, 1'b1, 16'hFFF8, 3'b111);
    step(); issue(3'd0, 3'd0, 3'd0, 1'b0, 16'h1111, 3'b000);
    @(negedge clk);
    check("r0_a", bus.a, 16'h0000);
    check("r0_b_imm", bus.b, 16'hFFF8);
    step(); idle();
    @(negedge clk);
    check("r0_b_reg", bus.b, 16'h0000);

    // Reset while full discards the bundle, registers and pending bits.
    step(); bus.wbEn = 1'b1; bus.wbAddr = 3'd2; bus.wbData = 16'h00AA;
    step(); bus.wbEn = 1'b0; issue(3'd2, 3'd0, 3'd6, 1'b1, 16'h0001, 3'b010);
    bus.outReady = 1'b0;
    step(); idle();
    @(negedge clk);
    check("pre_rst_valid", bus.outValid, 1);
    check("pre_rst_a", bus.a, 16'h00AA);
    step(); rst = 1'b1;
    step(); rst = 1'b0; bus.outReady = 1'b1;
    @(negedge clk);
    check("post_rst_valid", bus.outValid, 0);
    check("post_rst_b", bus.b, 16'h0000);
    step(); issue(3'd2, 3'd6, 3'd0, 1'b0, 16'h0, 3'b011);
    @(negedge clk);
    check("post_rst_ready", bus.inReady, 1);
    step(); idle();
    @(negedge clk);
    check("post_rst_a", bus.a, 16'h0000);
    check("post_rst_b2", bus.b, 16'h0000);

    // Mixed traffic, checked by the model alone.
    for (int i = 0; i < 80; i++) begin
      step();
      bus.inValid  = ($urandom_range(0, 3) != 0);
      bus.rs       = 3'($urandom_range(0, 7));
      bus.rt       = 3'($urandom_range(0, 7));
      bus.rd       = 3'($urandom_range(0, 7));
      bus.useImm   = ($urandom_range(0, 2) == 0);
      bus.imm      = 16'($urandom);
      bus.aluOpIn  = 3'($urandom_range(0, 7));
      bus.outReady = ($urandom_range(0, 9) < 7);
      bus.wbEn     = ($urandom_range(0, 1) == 1);
      bus.wbAddr   = 3'($urandom_range(0, 7));
      bus.wbData   = 16'($urandom);
    end
    step(); idle(); bus.outReady = 1'b1;
    step(); step();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
